// File: rtl/sd_spi_master_pkg.sv
// Shared constants for the SD card SPI master: FSM encodings, idle levels and phase limits.
package sd_spi_master_pkg;

    localparam logic [0:0] ST_IDLE        = 1'b0;
    localparam logic [0:0] ST_SHIFT       = 1'b1;
    localparam logic       SPI_IDLE_MOSI  = 1'b1;
    localparam logic [7:0] SPI_RESET_DATA = 8'hFF;
    localparam logic [3:0] LAST_PHASE     = 4'd15;

endpackage

// File: rtl/sd_spi_master_if.sv
// Byte handshake between the Z80 port block (master side) and the SD SPI engine (slave side).
interface sd_spi_master_if #(
    parameter int DIV_W = 4
) ();
    logic             sd_start;
    logic [7:0]       sd_datain;
    logic [7:0]       sd_dataout;
    logic [DIV_W-1:0] spi_div;
    logic             busy;
    logic             done;

    modport master (
        output sd_start, sd_datain, spi_div,
        input  sd_dataout, busy, done
    );

    modport slave (
        input  sd_start, sd_datain, spi_div,
        output sd_dataout, busy, done
    );
endinterface

// File: rtl/sd_spi_master_tick_gen.sv
// SCLK half-period tick generator; the divider exists only with SD_SPI_DIV_EN defined,
// otherwise tick is constant 1 and every clk cycle advances the SPI phase.
module spi_tick_gen #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
`ifdef SD_SPI_DIV_EN
    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == '0);

    // Reload on each tick so a half-period always lasts div+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= div;
        end else begin
            cnt <= cnt - {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{clk, rst_n, load, div};
    assign tick          = 1'b1;
`endif
endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for the SD slot: 16 ticks per byte, MSB first, MISO sampled on SCLK fall.
// Optional slow clock divider via SD_SPI_DIV_EN (see spi_tick_gen).
module sd_spi_master
    import sd_spi_master_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sd_spi_master_if.slave    bus,
    output logic              sdclk,
    output logic              sddo,
    input  logic              sddi
);
    logic [0:0] state;
    logic [3:0] phase;
    logic [6:0] tx;
    logic [6:0] rx;
    logic [7:0] dataout;
    logic       busy;
    logic       done;
    logic       tick;
    logic       last_tick;
    logic       accept;

    spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .div   (bus.spi_div),
        .tick  (tick)
    );

    assign last_tick = (state == ST_SHIFT) && (phase == LAST_PHASE) && tick;
    // A new byte may chain onto the final tick so back-to-back transfers keep busy high.
    assign accept    = bus.sd_start && ((state == ST_IDLE) || last_tick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            phase   <= 4'd0;
            tx      <= 7'd0;
            rx      <= 7'd0;
            dataout <= SPI_RESET_DATA;
            busy    <= 1'b0;
            done    <= 1'b0;
            sdclk   <= 1'b0;
            sddo    <= SPI_IDLE_MOSI;
        end else begin
            done <= 1'b0;
            if (last_tick) begin
                sdclk   <= 1'b0;
                dataout <= {rx, sddi};
                done    <= 1'b1;
                sddo    <= SPI_IDLE_MOSI;
                busy    <= 1'b0;
                state   <= ST_IDLE;
            end else if ((state == ST_SHIFT) && tick) begin
                if (!phase[0]) begin
                    sdclk <= 1'b1;
                end else begin
                    sdclk <= 1'b0;
                    rx    <= {rx[5:0], sddi};
                    tx    <= {tx[5:0], 1'b0};
                    sddo  <= tx[6];
                end
                phase <= phase + 4'd1;
            end

            // Acceptance overrides completion's idle values but not its dataout/done update.
            if (accept) begin
                tx    <= bus.sd_datain[6:0];
                sddo  <= bus.sd_datain[7];
                phase <= 4'd0;
                sdclk <= 1'b0;
                busy  <= 1'b1;
                state <= ST_SHIFT;
            end
        end
    end

    assign bus.sd_dataout = dataout;
    assign bus.busy       = busy;
    assign bus.done       = done;
endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master; cycle numbers count rising edges after the accepting edge.
module tb_sd_spi_master;
    logic clk;
    logic rst_n;
    logic sdclk;
    logic sddo;
    logic sddi;
    logic loop_en;
    logic miso_bit;
    logic [7:0] miso_sh;
    int checks;
    int failures;

    sd_spi_master_if #(.DIV_W(4)) bus ();

    sd_spi_master #(.DIV_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sdclk (sdclk),
        .sddo  (sddo),
        .sddi  (sddi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MISO model: presents the next pattern bit after each SCLK rise.
    always @(posedge sdclk) begin
        miso_bit <= miso_sh[7];
        miso_sh  <= {miso_sh[6:0], 1'b0};
    end

    assign sddi = loop_en ? sddo : miso_bit;

    task automatic start_byte(input logic [7:0] din);
        @(negedge clk);
        bus.sd_start  = 1'b1;
        bus.sd_datain = din;
        @(posedge clk);
        #1;
        bus.sd_start = 1'b0;
    endtask

    // Runs one transfer; done is expected at cycle 16 (the spec's N+17 numbering).
    task automatic xfer(input logic [7:0] din, input int budget, output int lat,
                        output logic [7:0] mosi, output int rises, output int dones,
                        output bit busy_low, output bit mosi_low, output int hi_cnt);
        logic prev;
        lat = -1; mosi = 8'h00; rises = 0; dones = 0; busy_low = 0; mosi_low = 0; hi_cnt = 0;
        start_byte(din);
        prev = sdclk;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (sdclk && !prev) begin
                rises++;
                mosi = {mosi[6:0], sddo};
            end
            if (sdclk) hi_cnt++;
            if (lat < 0 && !bus.done && !bus.busy) busy_low = 1;
            if (lat < 0 && !bus.done && !sddo) mosi_low = 1;
            if (bus.done) begin
                dones++;
                if (lat < 0) lat = c;
            end
            prev = sdclk;
            if (lat >= 0 && c >= lat + 4) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (sdclk !== 1'b0 || sddo !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.sd_dataout !== 8'hFF) begin
            failures++;
            $display("FAIL reset_values: sdclk=%b sddo=%b busy=%b done=%b dout=%h, want 0 1 0 0 ff",
                     sdclk, sddo, bus.busy, bus.done, bus.sd_dataout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (sdclk !== 1'b0 || sddo !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
                bus.sd_dataout !== 8'hFF) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: sdclk=%b sddo=%b busy=%b done=%b dout=%h",
                         i, sdclk, sddo, bus.busy, bus.done, bus.sd_dataout);
            end
        end
    endtask

    task automatic test_loopback();
        int lat, rises, dones, hi;
        logic [7:0] mosi;
        bit bl, ml;
        loop_en = 1'b1;
        xfer(8'hA5, 100, lat, mosi, rises, dones, bl, ml, hi);
        checks++;
        if (lat !== 16) begin failures++; $display("FAIL loop_latency: got %0d want 16", lat); end
        checks++;
        if (mosi !== 8'hA5) begin failures++; $display("FAIL loop_mosi: got %h want a5", mosi); end
        checks++;
        if (rises !== 8) begin failures++; $display("FAIL loop_rises: got %0d want 8", rises); end
        checks++;
        if (bus.sd_dataout !== 8'hA5) begin
            failures++; $display("FAIL loop_dout: got %h want a5", bus.sd_dataout);
        end
        checks++;
        if (bl) begin failures++; $display("FAIL loop_busy: busy dropped before done, want steady 1"); end
    endtask

    task automatic test_miso();
        int lat, rises, dones, hi;
        logic [7:0] mosi;
        bit bl, ml;
        loop_en = 1'b0;
        miso_sh = 8'h3C;
        xfer(8'hFF, 100, lat, mosi, rises, dones, bl, ml, hi);
        checks++;
        if (bus.sd_dataout !== 8'h3C) begin
            failures++; $display("FAIL miso_dout: got %h want 3c", bus.sd_dataout);
        end
        checks++;
        if (ml || mosi !== 8'hFF) begin
            failures++; $display("FAIL miso_mosi_high: low_seen=%0d mosi=%h want 0 ff", ml, mosi);
        end
        checks++;
        if (dones !== 1) begin failures++; $display("FAIL miso_done_once: got %0d want 1", dones); end
    endtask

    task automatic test_ignore();
        int lat;
        int dones;
        lat = -1;
        dones = 0;
        loop_en = 1'b1;
        start_byte(8'hA5);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) begin
                bus.sd_start  = 1'b1;
                bus.sd_datain = 8'h00;
            end else begin
                bus.sd_start = 1'b0;
            end
            if (bus.done) begin
                dones++;
                if (lat < 0) lat = c;
            end
        end
        checks++;
        if (lat !== 16 || dones !== 1) begin
            failures++; $display("FAIL ignore_timing: lat=%0d dones=%0d want 16 1", lat, dones);
        end
        checks++;
        if (bus.sd_dataout !== 8'hA5) begin
            failures++; $display("FAIL ignore_dout: got %h want a5", bus.sd_dataout);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [7:0] o1, o2;
        bit dropped;
        d1 = -1; d2 = -1; o1 = 8'h00; o2 = 8'h00; dropped = 0;
        loop_en = 1'b1;
        start_byte(8'h5A);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            bus.sd_start = 1'b0;
            if (c < 32 && !bus.busy) dropped = 1;
            if (bus.done) begin
                if (d1 < 0) begin d1 = c; o1 = bus.sd_dataout; end
                else if (d2 < 0) begin d2 = c; o2 = bus.sd_dataout; end
            end
            if (c == 15) begin
                bus.sd_start  = 1'b1;
                bus.sd_datain = 8'hC3;
            end
        end
        checks++;
        if (d1 !== 16 || d2 !== 32) begin
            failures++; $display("FAIL b2b_done_cycles: got %0d %0d want 16 32", d1, d2);
        end
        checks++;
        if (o1 !== 8'h5A || o2 !== 8'hC3) begin
            failures++; $display("FAIL b2b_data: got %h %h want 5a c3", o1, o2);
        end
        checks++;
        if (dropped) begin failures++; $display("FAIL b2b_busy: busy dropped, want held 1"); end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        loop_en = 1'b1;
        start_byte(8'hA5);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sdclk !== 1'b0 || sddo !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.sd_dataout !== 8'hFF) begin
            failures++;
            $display("FAIL abort_values: sdclk=%b sddo=%b busy=%b done=%b dout=%h want 0 1 0 0 ff",
                     sdclk, sddo, bus.busy, bus.done, bus.sd_dataout);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0 || bus.sd_dataout !== 8'hFF || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_after: dones=%0d dout=%h busy=%b want 0 ff 0", dones, bus.sd_dataout, bus.busy);
        end
    endtask

    task automatic test_divider();
        int lat, rises, dones, hi;
        logic [7:0] mosi;
        bit bl, ml;
        loop_en = 1'b1;
        bus.spi_div = 4'd3;
        xfer(8'h96, 200, lat, mosi, rises, dones, bl, ml, hi);
`ifdef SD_SPI_DIV_EN
        checks++;
        if (lat !== 64) begin failures++; $display("FAIL div3_latency: got %0d want 64", lat); end
        checks++;
        if (hi !== 32) begin failures++; $display("FAIL div3_high_cycles: got %0d want 32", hi); end
`else
        checks++;
        if (lat !== 16) begin failures++; $display("FAIL div3_ignored_latency: got %0d want 16", lat); end
        checks++;
        if (hi !== 8) begin failures++; $display("FAIL div3_ignored_high: got %0d want 8", hi); end
`endif
        checks++;
        if (bus.sd_dataout !== 8'h96 || mosi !== 8'h96) begin
            failures++; $display("FAIL div3_data: dout=%h mosi=%h want 96 96", bus.sd_dataout, mosi);
        end
        bus.spi_div = 4'd0;
        xfer(8'h3E, 100, lat, mosi, rises, dones, bl, ml, hi);
        checks++;
        if (lat !== 16 || bus.sd_dataout !== 8'h3E) begin
            failures++; $display("FAIL div0: lat=%0d dout=%h want 16 3e", lat, bus.sd_dataout);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        loop_en = 1'b1;
        miso_sh = 8'h00;
        miso_bit = 1'b1;
        bus.sd_start = 1'b0;
        bus.sd_datain = 8'h00;
        bus.spi_div = 4'd0;
        test_reset();
        test_loopback();
        test_miso();
        test_ignore();
        test_back_to_back();
        test_abort();
        test_divider();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
